// File: rtl/bilinear_scale_engine.sv
// bilinear_scale_engine: 2x2-neighbourhood bilinear upscaler emitting S*S target pixels per quad, one per cycle.
// Optional macro BILIN_NEAREST_EN adds input nearest_i selecting nearest-neighbour replication weights.
module bilinear_scale_engine #(
  parameter int  DW        = 8,
  parameter int  FRAC      = 8,
  parameter int  MAX_SCALE = 4,
  localparam int SW        = $clog2(MAX_SCALE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] scale_i,
`ifdef BILIN_NEAREST_EN
  input  logic          nearest_i,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] p00,
  input  logic [DW-1:0] p10,
  input  logic [DW-1:0] p01,
  input  logic [DW-1:0] p11,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pix,
  output logic [SW-1:0] out_tx,
  output logic [SW-1:0] out_ty,
  output logic          out_last,
  output logic          busy
);

  localparam int WW = FRAC + 1;
  localparam int TW = DW + FRAC + 1;
  localparam int AW = DW + 2 * FRAC + 1;
  localparam int RW = AW + 1;
  localparam int NS = 1 << SW;
  localparam logic [WW-1:0] W_ONE = WW'(1) << FRAC;
  localparam logic [RW-1:0] RND   = RW'(1) << (2 * FRAC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_reg;
  logic [SW-1:0] scale_reg;
  logic [SW-1:0] i_reg;
  logic [SW-1:0] j_reg;
  logic [DW-1:0] p00_reg, p10_reg, p01_reg, p11_reg;

  logic          s1_valid_reg;
  logic [TW-1:0] s1_top_reg, s1_bot_reg;
  logic [WW-1:0] s1_wy_reg;
  logic [SW-1:0] s1_tx_reg, s1_ty_reg;
  logic          s1_last_reg;

  logic          s2_valid_reg;
  logic [AW-1:0] s2_acc_reg;
  logic [SW-1:0] s2_tx_reg, s2_ty_reg;
  logic          s2_last_reg;

  logic          adv;
  logic          issue;
  logic          accept;
  logic          last_pos;
  logic          row_end;
  logic [SW-1:0] scale_max1;
  logic [SW-1:0] scale_eff;
  logic [WW-1:0] wx, wy, wx_c, wy_c;
  logic [TW-1:0] top_next, bot_next;
  logic [AW-1:0] acc_next;
  logic [RW-1:0] rnd_sum;
  logic [DW-1:0] pix_next;

  // Per-scale weight tables indexed by {S, k}; entries outside 1<=S, k<S are never selected.
  logic [WW-1:0] bil_lut [NS*NS];
  for (genvar gi = 0; gi < NS; gi++) begin : g_scale
    for (genvar gk = 0; gk < NS; gk++) begin : g_pos
      if (gi >= 1 && gk < gi) begin : g_w
        assign bil_lut[gi*NS+gk] = WW'((gk * (1 << FRAC) + gi / 2) / gi);
      end else begin : g_z
        assign bil_lut[gi*NS+gk] = '0;
      end
    end
  end

`ifdef BILIN_NEAREST_EN
  logic          nearest_reg;
  logic [WW-1:0] nn_lut [NS*NS];
  for (genvar gi = 0; gi < NS; gi++) begin : g_nn_scale
    for (genvar gk = 0; gk < NS; gk++) begin : g_nn_pos
      if (gi >= 1 && gk < gi && 2 * gk >= gi) begin : g_one
        assign nn_lut[gi*NS+gk] = W_ONE;
      end else begin : g_zero
        assign nn_lut[gi*NS+gk] = '0;
      end
    end
  end

  assign wx = nearest_reg ? nn_lut[{scale_reg, i_reg}] : bil_lut[{scale_reg, i_reg}];
  assign wy = nearest_reg ? nn_lut[{scale_reg, j_reg}] : bil_lut[{scale_reg, j_reg}];
`else
  assign wx = bil_lut[{scale_reg, i_reg}];
  assign wy = bil_lut[{scale_reg, j_reg}];
`endif

  always_comb begin
    scale_eff = scale_i;
    if (scale_i == '0) begin
      scale_eff = SW'(1);
    end else if (scale_i > SW'(MAX_SCALE)) begin
      scale_eff = SW'(MAX_SCALE);
    end
  end

  assign adv        = !out_valid || out_ready;
  assign issue      = (state_reg == ST_RUN) && adv;
  assign scale_max1 = scale_reg - SW'(1);
  assign row_end    = (i_reg == scale_max1);
  assign last_pos   = row_end && (j_reg == scale_max1);
  // Quad handover happens on the final-position issue so consecutive quads stream without a bubble.
  assign in_ready   = rst_n && ((state_reg == ST_IDLE) || (issue && last_pos));
  assign accept     = in_valid && in_ready;
  assign busy       = (state_reg == ST_RUN) || s1_valid_reg || s2_valid_reg || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      scale_reg <= SW'(1);
      i_reg     <= '0;
      j_reg     <= '0;
      p00_reg   <= '0;
      p10_reg   <= '0;
      p01_reg   <= '0;
      p11_reg   <= '0;
`ifdef BILIN_NEAREST_EN
      nearest_reg <= 1'b0;
`endif
    end else if (accept) begin
      state_reg <= ST_RUN;
      scale_reg <= scale_eff;
      i_reg     <= '0;
      j_reg     <= '0;
      p00_reg   <= p00;
      p10_reg   <= p10;
      p01_reg   <= p01;
      p11_reg   <= p11;
`ifdef BILIN_NEAREST_EN
      nearest_reg <= nearest_i;
`endif
    end else if (issue) begin
      if (last_pos) begin
        state_reg <= ST_IDLE;
      end else if (row_end) begin
        i_reg <= '0;
        j_reg <= j_reg + SW'(1);
      end else begin
        i_reg <= i_reg + SW'(1);
      end
    end
  end

  assign wx_c     = W_ONE - wx;
  assign wy_c     = W_ONE - s1_wy_reg;
  assign top_next = TW'(p00_reg) * TW'(wx_c) + TW'(p10_reg) * TW'(wx);
  assign bot_next = TW'(p01_reg) * TW'(wx_c) + TW'(p11_reg) * TW'(wx);
  assign acc_next = AW'(s1_top_reg) * AW'(wy_c) + AW'(s1_bot_reg) * AW'(s1_wy_reg);

  // Weights always sum to one unit, so saturation only guards against table misuse.
  assign rnd_sum  = RW'(s2_acc_reg) + RND;
  assign pix_next = (|rnd_sum[RW-1:2*FRAC+DW]) ? '1 : rnd_sum[2*FRAC+DW-1:2*FRAC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_top_reg   <= '0;
      s1_bot_reg   <= '0;
      s1_wy_reg    <= '0;
      s1_tx_reg    <= '0;
      s1_ty_reg    <= '0;
      s1_last_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_acc_reg   <= '0;
      s2_tx_reg    <= '0;
      s2_ty_reg    <= '0;
      s2_last_reg  <= 1'b0;
      out_valid    <= 1'b0;
      out_pix      <= '0;
      out_tx       <= '0;
      out_ty       <= '0;
      out_last     <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= issue;
      s1_top_reg   <= top_next;
      s1_bot_reg   <= bot_next;
      s1_wy_reg    <= wy;
      s1_tx_reg    <= i_reg;
      s1_ty_reg    <= j_reg;
      s1_last_reg  <= last_pos;
      s2_valid_reg <= s1_valid_reg;
      s2_acc_reg   <= acc_next;
      s2_tx_reg    <= s1_tx_reg;
      s2_ty_reg    <= s1_ty_reg;
      s2_last_reg  <= s1_last_reg;
      out_valid    <= s2_valid_reg;
      out_pix      <= pix_next;
      out_tx       <= s2_tx_reg;
      out_ty       <= s2_ty_reg;
      out_last     <= s2_last_reg;
    end
  end

endmodule
